// File: rtl/bo_datapath.sv
// bo_datapath: working registers X/H/S, add/multiply ALU with operand and
// writeback muxes, and a result register handed to a consumer through a
// valid/ack handshake. Sticky flags report arithmetic overflow and results
// dropped while the previous one was still unconsumed.
module bo_datapath #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] CONST_A = 8'd3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] x_in,
    input  logic             LX,
    input  logic             LH,
    input  logic             LS,
    input  logic             Hula,
    input  logic [1:0]       M0,
    input  logic [1:0]       M1,
    input  logic [1:0]       M2,
    input  logic             res_ack,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] res_data,
    output logic             res_valid,
    output logic             ovf,
    output logic             overrun,
    output logic [WIDTH-1:0] x_q,
    output logic [WIDTH-1:0] h_q,
    output logic [WIDTH-1:0] s_q
);

    typedef enum logic {EMPTY, FULL} hs_state_t;

    hs_state_t          state;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] full;
    logic [WIDTH-1:0]   alu;
    logic               alu_ovf;
    logic [WIDTH-1:0]   wb;
    logic               msb_loss;
    logic               ovf_set;
    logic               overrun_set;

    // Operand muxes feeding the ALU
    always_comb begin
        op_a = x_q;
        unique case (M0)
            2'd0: op_a = x_q;
            2'd1: op_a = h_q;
            2'd2: op_a = s_q;
            2'd3: op_a = CONST_A;
        endcase
        op_b = '0;
        unique case (M1)
            2'd0: op_b = '0;
            2'd1: op_b = x_q;
            2'd2: op_b = h_q;
            2'd3: op_b = s_q;
        endcase
    end

    // ALU: full-precision result, truncated to WIDTH; anything above is overflow
    always_comb begin
        sum     = {1'b0, op_a} + {1'b0, op_b};
        prod    = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
        full    = Hula ? prod : {{(WIDTH-1){1'b0}}, sum};
        alu     = full[WIDTH-1:0];
        alu_ovf = |full[2*WIDTH-1:WIDTH];
    end

    // Writeback transform; a left shift that pushes out a 1 counts as overflow
    always_comb begin
        wb       = alu;
        msb_loss = 1'b0;
        unique case (M2)
            2'd0: wb = alu;
            2'd1: wb = alu >> 1;
            2'd2: begin
                wb       = {alu[WIDTH-2:0], 1'b0};
                msb_loss = alu[WIDTH-1];
            end
            2'd3: wb = alu;
        endcase
        ovf_set     = (LH || LS) && (alu_ovf || msb_loss);
        overrun_set = (state == FULL) && LS && !res_ack;
    end

    // Working registers; simultaneous strobes all see pre-edge values
    always_ff @(posedge clk) begin
        if (!reset) begin
            x_q <= '0;
            h_q <= '0;
            s_q <= '0;
        end else begin
            if (LX) x_q <= x_in;
            if (LH) h_q <= wb;
            if (LS) s_q <= wb;
        end
    end

    // Sticky flags: a set in the same cycle as clr_flags wins
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (ovf_set)        ovf <= 1'b1;
            else if (clr_flags) ovf <= 1'b0;
            if (overrun_set)    overrun <= 1'b1;
            else if (clr_flags) overrun <= 1'b0;
        end
    end

    // Result handshake: capture on LS, release on res_ack, drop if still held
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= EMPTY;
            res_data <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (LS) begin
                        res_data <= wb;
                        state    <= FULL;
                    end
                end
                FULL: begin
                    if (LS && res_ack) res_data <= wb;
                    else if (res_ack)  state    <= EMPTY;
                end
            endcase
        end
    end

    assign res_valid = (state == FULL);

endmodule

// File: tb/tb_bo_datapath.sv
// Bench for bo_datapath: directed scenarios with literal expectations, then
// randomized strobes compared each cycle against a behavioural model.
module tb_bo_datapath;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] x_in = '0;
    logic       LX = 1'b0, LH = 1'b0, LS = 1'b0, Hula = 1'b0;
    logic [1:0] M0 = '0, M1 = '0, M2 = '0;
    logic       res_ack = 1'b0, clr_flags = 1'b0;
    logic [7:0] res_data, x_q, h_q, s_q;
    logic       res_valid, ovf, overrun;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    int mx, mh, ms, mrd;
    bit mvalid, movf, mover;

    bo_datapath #(.WIDTH(8), .CONST_A(8'd3)) dut (
        .clk(clk), .reset(reset), .x_in(x_in),
        .LX(LX), .LH(LH), .LS(LS), .Hula(Hula),
        .M0(M0), .M1(M1), .M2(M2),
        .res_ack(res_ack), .clr_flags(clr_flags),
        .res_data(res_data), .res_valid(res_valid),
        .ovf(ovf), .overrun(overrun),
        .x_q(x_q), .h_q(h_q), .s_q(s_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    endtask

    // Next-state of the whole block from current inputs, using plain arithmetic
    function automatic void model_update();
        int a, b, full, alu, wb;
        bit aovf, loss, ov_set, or_set;
        if (!reset) begin
            mx = 0; mh = 0; ms = 0; mrd = 0;
            mvalid = 0; movf = 0; mover = 0;
            return;
        end
        case (M0)
            2'd0: a = mx;
            2'd1: a = mh;
            2'd2: a = ms;
            default: a = 3;
        endcase
        case (M1)
            2'd0: b = 0;
            2'd1: b = mx;
            2'd2: b = mh;
            default: b = ms;
        endcase
        full = Hula ? a * b : a + b;
        alu  = full % 256;
        aovf = full > 255;
        loss = (M2 == 2) && (alu >= 128);
        case (M2)
            2'd1: wb = alu / 2;
            2'd2: wb = (alu * 2) % 256;
            default: wb = alu;
        endcase
        ov_set = (LH || LS) && (aovf || loss);
        or_set = mvalid && LS && !res_ack;
        movf  = ov_set ? 1'b1 : (clr_flags ? 1'b0 : movf);
        mover = or_set ? 1'b1 : (clr_flags ? 1'b0 : mover);
        if (!mvalid) begin
            if (LS) begin mrd = wb; mvalid = 1; end
        end else if (LS && res_ack) mrd = wb;
        else if (res_ack) mvalid = 0;
        if (LX) mx = x_in;
        if (LH) mh = wb;
        if (LS) ms = wb;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic op(input bit lx, input bit lh, input bit ls, input bit hula,
                      input int m0, input int m1, input int m2,
                      input bit ack, input bit clr, input int xin);
        LX = lx; LH = lh; LS = ls; Hula = hula;
        M0 = 2'(m0); M1 = 2'(m1); M2 = 2'(m2);
        res_ack = ack; clr_flags = clr; x_in = 8'(xin);
        tick();
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("x_q", int'(x_q), mx);
            chk("h_q", int'(h_q), mh);
            chk("s_q", int'(s_q), ms);
            chk("res_data", int'(res_data), mrd);
            chk("res_valid", int'(res_valid), int'(mvalid));
            chk("ovf", int'(ovf), int'(movf));
            chk("overrun", int'(overrun), int'(mover));
        end
    end

    initial begin
        // Reset held with LX active: X must stay 0
        reset = 1'b0;
        op(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h55);
        chk_en = 1'b1;
        op(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h55);
        chk("rst_x", int'(x_q), 0);
        chk("rst_valid", int'(res_valid), 0);
        chk("rst_rd", int'(res_data), 0);
        reset = 1'b1;

        // Load and add
        op(1, 0, 0, 0, 0, 0, 0, 0, 0, 5);
        op(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("add_h", int'(h_q), 10);
        chk("add_ovf", int'(ovf), 0);

        // Multiply wrap
        op(1, 0, 0, 0, 0, 0, 0, 0, 0, 20);
        op(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        op(0, 0, 1, 1, 0, 2, 0, 0, 0, 0);
        chk("mul_s", int'(s_q), 8'h90);
        chk("mul_ovf", int'(ovf), 1);
        chk("mul_valid", int'(res_valid), 1);
        chk("mul_rd", int'(res_data), 8'h90);
        op(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("clr_ovf", int'(ovf), 0);
        op(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Handshake with overrun
        op(1, 0, 0, 0, 0, 0, 0, 0, 0, 7);
        op(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("hs_rd7", int'(res_data), 7);
        op(1, 0, 0, 0, 0, 0, 0, 0, 0, 9);
        op(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("ovr_rd", int'(res_data), 7);
        chk("ovr_flag", int'(overrun), 1);
        chk("ovr_s", int'(s_q), 9);
        op(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("ack_valid", int'(res_valid), 0);
        op(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("clr_ovr", int'(overrun), 0);

        // Simultaneous ack and capture
        op(1, 0, 0, 0, 0, 0, 0, 0, 0, 7);
        op(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        op(1, 0, 0, 0, 0, 0, 0, 0, 0, 12);
        op(0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        chk("sim_rd", int'(res_data), 12);
        chk("sim_valid", int'(res_valid), 1);
        chk("sim_ovr", int'(overrun), 0);

        // Reset mid-sequence while FULL
        reset = 1'b0;
        op(1, 1, 1, 0, 0, 1, 0, 0, 0, 8'hAA);
        chk("mid_valid", int'(res_valid), 0);
        chk("mid_rd", int'(res_data), 0);
        chk("mid_x", int'(x_q), 0);
        reset = 1'b1;

        // Writeback transforms and constant operand
        op(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'hC2);
        op(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("shr_h", int'(h_q), 8'h61);
        chk("shr_ovf", int'(ovf), 0);
        op(0, 1, 0, 0, 0, 0, 2, 0, 0, 0);
        chk("shl_h", int'(h_q), 8'h84);
        chk("shl_ovf", int'(ovf), 1);
        op(0, 0, 1, 0, 3, 0, 0, 0, 0, 0);
        chk("const_s", int'(s_q), 3);
        chk("const_rd", int'(res_data), 3);

        // Randomized strobes against the model
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 60) != 0);
            op($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
               $urandom_range(0, 255));
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
